// File: rtl/pll_spi_cfg_arbiter.sv
// pll_spi_cfg_arbiter: round-robin share of one PLL SPI config master among NUM_REQ requesters.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   req_valid    per-requester frame pending (held until req_ready)
//   req_data     packed frames, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    one-hot accept pulse, frame captured in that cycle
//   req_done     one-hot completion pulse to the granted requester
//   req_err      with req_done when the frame was abandoned on timeout
//   spi_start    one-cycle start pulse to the SPI master
//   spi_data     latched frame presented to the SPI master
//   spi_finish   SPI master finish pulse, honoured only while waiting
//   busy         high whenever not idle
module pll_spi_cfg_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 512,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          req_err,
  output logic                          spi_start,
  output logic [DATA_WIDTH-1:0]         spi_data,
  input  logic                          spi_finish,
  output logic                          busy
);
  localparam int MAXC = GAP_CYCLES > TIMEOUT_CYCLES ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, WAIT, DONE, GAP} state_t;
  state_t state, state_nxt;
  logic [NUM_REQ-1:0] gnt, last, hi_mask, masked, cand, pick;
  logic [CW-1:0] cnt;
  logic err;
  logic [DATA_WIDTH-1:0] frame;
  // Requesters strictly above the last grant win first; otherwise wrap to the lowest valid.
  // last is one-hot, so (last<<1)-1 covers every index up to and including it.
  assign hi_mask = ~((last << 1) - NUM_REQ'(1));
  assign masked  = req_valid & hi_mask;
  assign cand    = |masked ? masked : req_valid;
  assign pick    = cand & (~cand + NUM_REQ'(1));
  always_comb begin
    frame = '0;
    for (int i = 0; i < NUM_REQ; i++)
      frame = frame | (gnt[i] ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    req_ready = state == GRANT ? gnt : '0;
    req_done  = state == DONE ? gnt : '0;
    req_err   = state == DONE && err;
    spi_start = state == LAUNCH;
    busy      = state != IDLE;
    case (state)
      IDLE:    state_nxt = |req_valid ? GRANT : IDLE;
      GRANT:   state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    state_nxt = (spi_finish || cnt == CW'(TIMEOUT_CYCLES - 1)) ? DONE : WAIT;
      DONE:    state_nxt = GAP;
      GAP:     state_nxt = cnt == CW'(GAP_CYCLES - 1) ? IDLE : GAP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt      <= '0;
      last     <= NUM_REQ'(1) << (NUM_REQ - 1);
      cnt      <= '0;
      err      <= 1'b0;
      spi_data <= '0;
    end else begin
      if (state == IDLE && |req_valid) begin
        gnt  <= pick;
        last <= pick;
      end
      if (state == GRANT) spi_data <= frame;
      // Finish has priority over timeout when both land in the same cycle.
      if (state == WAIT) err <= !spi_finish;
      cnt <= (state == WAIT || state == GAP) ? cnt + CW'(1) : '0;
    end
endmodule

// File: tb/tb_pll_spi_cfg_arbiter.sv
// tb_pll_spi_cfg_arbiter: directed self-checking bench for pll_spi_cfg_arbiter.
module tb_pll_spi_cfg_arbiter;
  localparam int NR = 2;
  localparam int DW = 512;
  localparam int G  = 16;
  localparam int TO = 100;
  localparam logic [DW-1:0] PA5 = {64{8'hA5}};
  localparam logic [DW-1:0] P1  = {128{4'h1}};
  localparam logic [DW-1:0] P2  = {128{4'h2}};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0] req_ready, req_done;
  logic req_err, spi_start, spi_finish = 1'b0, busy;
  logic [DW-1:0] spi_data;
  int pass = 0;
  int total = 0;
  pll_spi_cfg_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .GAP_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err), .spi_start(spi_start),
    .spi_data(spi_data), .spi_finish(spi_finish), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass++;
    total++; if (req_ready !== 2'b00) $display("FAIL reset_ready got %b exp 00", req_ready); else pass++;
    total++; if (req_done !== 2'b00) $display("FAIL reset_done got %b exp 00", req_done); else pass++;
    total++; if (req_err !== 1'b0) $display("FAIL reset_err got %b exp 0", req_err); else pass++;
    total++; if (spi_start !== 1'b0) $display("FAIL reset_start got %b exp 0", spi_start); else pass++;
    total++; if (spi_data !== '0) $display("FAIL reset_data got %h exp 0", spi_data); else pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_single;
    int bad;
    req_data = {P2, PA5};
    req_valid = 2'b01;
    @(negedge clk);
    total++; if (req_ready !== 2'b01) $display("FAIL single_ready got %b exp 01", req_ready); else pass++;
    total++; if (spi_start !== 1'b0) $display("FAIL single_start_early got %b exp 0", spi_start); else pass++;
    req_valid = 2'b00;
    @(negedge clk);
    total++; if (spi_start !== 1'b1) $display("FAIL single_start got %b exp 1", spi_start); else pass++;
    total++; if (req_ready !== 2'b00) $display("FAIL single_ready_len got %b exp 00", req_ready); else pass++;
    total++; if (spi_data !== PA5) $display("FAIL single_data got %h exp %h", spi_data, PA5); else pass++;
    @(negedge clk);
    total++; if (spi_start !== 1'b0) $display("FAIL single_start_len got %b exp 0", spi_start); else pass++;
    repeat (59) @(negedge clk);
    spi_finish = 1'b1;
    @(negedge clk);
    spi_finish = 1'b0;
    total++; if (req_done !== 2'b01) $display("FAIL single_done got %b exp 01", req_done); else pass++;
    total++; if (req_err !== 1'b0) $display("FAIL single_err got %b exp 0", req_err); else pass++;
    bad = 0;
    for (int i = 0; i < G; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || req_done !== 2'b00) bad++;
    end
    total++; if (bad != 0) $display("FAIL single_gap_busy got %0d bad cycles exp 0", bad); else pass++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL single_idle got %b exp 0", busy); else pass++;
  endtask
  task automatic test_contention;
    logic [NR-1:0] exp;
    logic [DW-1:0] ed;
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_data = {P2, P1};
    req_valid = 2'b11;
    for (int f = 0; f < 4; f++) begin
      exp = (f % 2 == 0) ? 2'b01 : 2'b10;
      ed = (f % 2 == 0) ? P1 : P2;
      n = 0;
      while (req_ready === 2'b00 && n < 100) begin
        @(negedge clk);
        n++;
      end
      total++; if (req_ready !== exp) $display("FAIL cont_ready%0d got %b exp %b", f, req_ready, exp); else pass++;
      @(negedge clk);
      total++; if (req_ready !== 2'b00 || spi_start !== 1'b1)
        $display("FAIL cont_launch%0d got ready %b start %b exp 00/1", f, req_ready, spi_start); else pass++;
      total++; if (spi_data !== ed) $display("FAIL cont_data%0d got %h exp %h", f, spi_data, ed); else pass++;
      repeat (3) @(negedge clk);
      spi_finish = 1'b1;
      @(negedge clk);
      spi_finish = 1'b0;
      total++; if (req_done !== exp) $display("FAIL cont_done%0d got %b exp %b", f, req_done, exp); else pass++;
    end
    req_valid = 2'b00;
    repeat (G + 2) @(negedge clk);
  endtask
  task automatic test_timeout;
    int bad, n;
    req_valid = 2'b01;
    n = 0;
    while (req_ready === 2'b00 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++; if (req_ready !== 2'b01) $display("FAIL to_ready got %b exp 01", req_ready); else pass++;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    bad = 0;
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      if (req_done !== 2'b00) bad++;
    end
    total++; if (bad != 0) $display("FAIL to_early_done got %0d exp 0", bad); else pass++;
    @(negedge clk);
    total++; if (req_done !== 2'b01 || req_err !== 1'b1)
      $display("FAIL to_done got done %b err %b exp 01/1", req_done, req_err); else pass++;
    bad = 0;
    for (int i = 1; i <= 30; i++) begin
      spi_finish = (i == 10 || i == 20);
      @(negedge clk);
      if (req_done !== 2'b00) bad++;
    end
    spi_finish = 1'b0;
    total++; if (bad != 0) $display("FAIL to_late_finish got %0d done cycles exp 0", bad); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL to_idle got %b exp 0", busy); else pass++;
  endtask
  task automatic test_gap;
    int n;
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    spi_finish = 1'b1;
    @(negedge clk);
    spi_finish = 1'b0;
    total++; if (req_done !== 2'b01) $display("FAIL gap_done got %b exp 01", req_done); else pass++;
    req_valid = 2'b10;
    n = 0;
    while (req_ready === 2'b00 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++; if (n != G + 2) $display("FAIL gap_latency got %0d exp %0d", n, G + 2); else pass++;
    total++; if (req_ready !== 2'b10) $display("FAIL gap_ready got %b exp 10", req_ready); else pass++;
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    spi_finish = 1'b1;
    @(negedge clk);
    spi_finish = 1'b0;
    repeat (G + 2) @(negedge clk);
  endtask
  task automatic test_finish_timeout;
    req_valid = 2'b01;
    @(negedge clk);
    total++; if (req_ready !== 2'b01) $display("FAIL ft_ready got %b exp 01", req_ready); else pass++;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    repeat (TO - 1) @(negedge clk);
    spi_finish = 1'b1;
    @(negedge clk);
    spi_finish = 1'b0;
    total++; if (req_done !== 2'b01 || req_err !== 1'b0)
      $display("FAIL ft_done got done %b err %b exp 01/0", req_done, req_err); else pass++;
    repeat (G + 2) @(negedge clk);
  endtask
  task automatic test_reset_mid;
    int n;
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || req_done !== 2'b00 || spi_start !== 1'b0 || req_ready !== 2'b00)
      $display("FAIL mid_reset got busy %b done %b start %b ready %b exp 0", busy, req_done, spi_start, req_ready); else pass++;
    total++; if (spi_data !== '0) $display("FAIL mid_reset_data got %h exp 0", spi_data); else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b11;
    n = 0;
    while (req_ready === 2'b00 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++; if (req_ready !== 2'b01) $display("FAIL mid_regrant got %b exp 01", req_ready); else pass++;
    req_valid = 2'b00;
  endtask
  initial begin
    test_reset;
    test_single;
    test_contention;
    test_timeout;
    test_gap;
    test_finish_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
